// File: rtl/lamp_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lamp_mode_ctrl_if
// Description : Key inputs and lamp-mode outputs of lamp_mode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface lamp_mode_ctrl_if;
    logic       key_n;
    logic       auto_n;
    logic [1:0] S;
    logic       mode_chg;
    logic       tick;
    logic       auto_en;

    modport master (
        output key_n,
        output auto_n,
        input  S,
        input  mode_chg,
        input  tick,
        input  auto_en
    );

    modport slave (
        input  key_n,
        input  auto_n,
        output S,
        output mode_chg,
        output tick,
        output auto_en
    );
endinterface
`default_nettype wire

// File: rtl/lamp_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lamp_mode_ctrl
// Description : Debounced mode / auto-cycle keys driving a 2-bit lamp pattern
//               select with a phase-aligned step tick.
// Revision    : 1.0 - initial release
// ============================================================================
module lamp_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TICK_DIV        = 5,
    parameter int AUTO_TICKS      = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lamp_mode_ctrl_if.slave bus
);

    localparam logic [15:0] c_deb_target = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] c_div_last   = 16'(TICK_DIV - 1);
    localparam logic [7:0]  c_auto_last  = 8'(AUTO_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } deb_state_t;

    // bit 0 = mode key, bit 1 = auto key; idle level of the keys is high
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_press;

    logic [1:0]  r_s;
    logic        r_mode_chg;
    logic        r_tick;
    logic        r_auto_en;
    logic [15:0] r_div;
    logic [7:0]  r_acnt;

    logic        w_auto_adv;
    logic        w_change;
    logic [15:0] w_div_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {bus.auto_n, bus.key_n};
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar k = 0; k < 2; k++) begin : g_deb
            deb_state_t  r_state;
            logic [15:0] r_cnt;
            logic [15:0] w_cnt_inc;

            // counter never exceeds DEBOUNCE_CYCLES-1, so the increment cannot wrap
            assign w_cnt_inc  = r_cnt + 16'd1;
            assign w_press[k] = (r_state == ST_PRESS_WAIT) && !r_sync2[k] &&
                                (w_cnt_inc == c_deb_target);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 16'd0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (!r_sync2[k]) begin
                                r_state <= ST_PRESS_WAIT;
                                r_cnt   <= 16'd1;
                            end
                        end
                        ST_PRESS_WAIT: begin
                            if (r_sync2[k]) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= 16'd0;
                            end else if (w_cnt_inc == c_deb_target) begin
                                r_state <= ST_HELD;
                                r_cnt   <= 16'd0;
                            end else begin
                                r_cnt   <= w_cnt_inc;
                            end
                        end
                        ST_HELD: begin
                            if (r_sync2[k]) begin
                                r_state <= ST_REL_WAIT;
                                r_cnt   <= 16'd1;
                            end
                        end
                        ST_REL_WAIT: begin
                            if (!r_sync2[k]) begin
                                r_state <= ST_HELD;
                                r_cnt   <= 16'd0;
                            end else if (w_cnt_inc == c_deb_target) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= 16'd0;
                            end else begin
                                r_cnt   <= w_cnt_inc;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 16'd0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // r_tick mirrors (r_div == TICK_DIV-1), so it marks the last cycle of a step
    assign w_auto_adv = r_auto_en && r_tick && (r_acnt == c_auto_last);
    assign w_change   = w_press[0] || w_auto_adv;
    assign w_div_next = (w_change || (r_div == c_div_last)) ? 16'd0 : (r_div + 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s        <= 2'b00;
            r_mode_chg <= 1'b0;
            r_tick     <= 1'b0;
            r_auto_en  <= 1'b0;
            r_div      <= 16'd0;
            r_acnt     <= 8'd0;
        end else begin
            r_div      <= w_div_next;
            r_tick     <= (w_div_next == c_div_last);
            r_mode_chg <= w_change;
            if (w_change) begin
                r_s <= r_s + 2'd1;
            end
            if (w_press[1]) begin
                r_auto_en <= ~r_auto_en;
            end
            // a mode change or an auto toggle restarts the auto count from zero
            if (w_change || w_press[1]) begin
                r_acnt <= 8'd0;
            end else if (r_auto_en && r_tick) begin
                r_acnt <= r_acnt + 8'd1;
            end
        end
    end

    assign bus.S        = r_s;
    assign bus.mode_chg = r_mode_chg;
    assign bus.tick     = r_tick;
    assign bus.auto_en  = r_auto_en;

endmodule
`default_nettype wire

// File: doc/lamp_mode_ctrl.md
LAMP_MODE_CTRL -- requirements
Module: lamp_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, consecutive stable synchronized samples needed to accept a key press or release; legal range 2..65535.
REQ-002 Parameter TICK_DIV, default 5, clk cycles per step-tick pulse; legal range 2..65535.
REQ-003 Parameter AUTO_TICKS, default 8, step-ticks between automatic mode advances; legal range 1..255.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 = reset.
REQ-006 key_n  input  1  mode push-button, active-low, asynchronous to clk, may bounce.
REQ-007 auto_n  input  1  auto-cycle push-button, active-low, asynchronous to clk, may bounce.
REQ-008 S  output  2  registered lamp pattern select, fed directly to the lamp pattern stage.
REQ-009 mode_chg  output  1  one-cycle pulse, high in the first cycle a new S value is presented.
REQ-010 tick  output  1  one-cycle step-enable pulse for the lamp pattern stage.
REQ-011 auto_en  output  1  registered auto-cycle enable status.

Function
REQ-012 key_n and auto_n each pass through a two-flop synchronizer; no combinational path from either key to any output.
REQ-013 Each synchronized key drives its own debounce FSM with states IDLE, PRESS_WAIT, HELD and REL_WAIT, plus a 16-bit stable counter.
REQ-014 IDLE: a synchronized low moves to PRESS_WAIT and sets the counter to 1.
REQ-015 PRESS_WAIT: a low increments the counter; a high returns to IDLE and clears the counter; reaching DEBOUNCE_CYCLES moves to HELD and emits a one-cycle internal press pulse.
REQ-016 HELD: a synchronized high moves to REL_WAIT with the counter at 1; holding the key low never emits further press pulses.
REQ-017 REL_WAIT: a high increments the counter; a low returns to HELD; reaching DEBOUNCE_CYCLES moves to IDLE.
REQ-018 Latency: edge 1 is the first rising edge sampling key_n low; if key_n stays low, S updates at edge DEBOUNCE_CYCLES+2.
REQ-019 Manual press: S <= S+1 modulo 4 (00->01->10->11->00).
REQ-020 auto_n press: auto_en toggles; S is unchanged.
REQ-021 tick divider: counts 0..TICK_DIV-1; tick is high during the cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
REQ-022 Auto counter: when auto_en=1, counts ticks 0..AUTO_TICKS-1; on the tick that completes AUTO_TICKS ticks, S <= S+1 modulo 4.
REQ-023 Any S change clears both the tick divider and the auto counter on the same edge, so the new mode starts phase-aligned.
REQ-024 A manual press and an auto advance on the same edge advance S by exactly 1, not 2.
REQ-025 auto_en toggling to 0 clears the auto counter; toggling to 1 starts the count from 0.
REQ-026 mode_chg asserts for exactly one cycle per S change, including an 11->00 wrap.

Reset
REQ-027 reset=0 asynchronously forces: S=00, mode_chg=0, tick=0, auto_en=0, both FSMs to IDLE, and all counters and synchronizer flops to their idle values (flops =1, counters =0).
REQ-028 reset asserted mid-debounce or mid-hold discards the pending press; after release, a key still held low must go through a full PRESS_WAIT before it is accepted.
REQ-029 After reset release, the first tick occurs TICK_DIV cycles after the first active edge.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5, AUTO_TICKS=3)
REQ-030 Reset, then keys idle 50 cycles -> S=00, auto_en=0, tick high every 5th cycle, mode_chg never high.
REQ-031 key_n held low 20 cycles -> S=01 from edge 6 on, with one mode_chg pulse; then release and press three more times -> S sequence 10, 11, 00.
REQ-032 key_n bounces low/high every 2 cycles for 20 cycles, then stays high -> S is unchanged and mode_chg never pulses.
REQ-033 auto_n pressed once -> auto_en=1; S advances every 15 cycles; the tick phase restarts at each advance.
REQ-034 Manual press accepted on the same edge as an auto advance -> S advances by 1 and mode_chg is a single one-cycle pulse.
REQ-035 reset pulsed low while key_n held low in HELD with S=10 -> S=00 immediately; no advance until key_n has been low for 4+2 edges after reset release.
